pl_hazard_ctrl: RTL
===================

PL_HAZARD_CTRL -- requirements
Module: pl_hazard_ctrl

Interface
REQ-001 The block SHALL have parameter MC_LAT, default 32, the number of RUN cycles for a multi-cycle (mul/div) operation; legal range 2..255.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, synchronous active-high reset.
REQ-004 The block SHALL have ports d_rs1 and d_rs2, input, 5 each, the decode-stage source register numbers.
REQ-005 The block SHALL have ports d_use_rs1 and d_use_rs2, input, 1 each, high when the decode-stage instruction reads that source.
REQ-006 The block SHALL have port d_mc, input, 1, high when the decode-stage instruction is multi-cycle.
REQ-007 The block SHALL have ports e_wreg, e_m2reg (input, 1 each) and e_rd (input, 5), the execute-stage write-enable, load flag and destination.
REQ-008 The block SHALL have ports m_wreg, m_m2reg (input, 1 each) and m_rd (input, 5), the memory-stage equivalents.
REQ-009 The block SHALL have port br_taken, input, 1, a taken branch or jump resolved in execute.
REQ-010 The block SHALL have ports fwda and fwdb, output, 2 each, operand source select: 00 register file, 01 E ALU result, 10 M ALU result, 11 M memory data.
REQ-011 The block SHALL have port wpcir, output, 1, PC and F/D register write enable; 0 holds both.
REQ-012 The block SHALL have port bubble_de, output, 1, which forces zero control bits into D/E.
REQ-013 The block SHALL have port flush_fd, output, 1, which turns F/D into a NOP.
REQ-014 The block SHALL have ports mc_start and mc_abort, output, 1 each, single-cycle pulses to the multi-cycle unit.
REQ-015 The block SHALL have port mc_busy, output, 1, high while the FSM is in START or RUN.
REQ-016 The block SHALL have port stall_cnt, output, 16, a saturating count of cycles with wpcir=0.

Function
REQ-017 Forwarding for a source SHALL depend on the register number r, which is d_rs1 or d_rs2.
REQ-018 If r=0, the forwarding select SHALL be 00.
REQ-019 If e_wreg and e_rd=r, the select SHALL be 01 when e_m2reg=0 and 00 when e_m2reg=1.
REQ-020 Otherwise, if m_wreg and m_rd=r, the select SHALL be 11 when m_m2reg=1, else 10.
REQ-021 Otherwise the select SHALL be 00.
REQ-022 Forwarding outputs SHALL be combinational, and the E stage SHALL take priority over M.
REQ-023 Load-use hazard lu SHALL be e_wreg & e_m2reg & e_rd!=0 & ((d_use_rs1 & d_rs1=e_rd) | (d_use_rs2 & d_rs2=e_rd)).
REQ-024 The FSM SHALL have states IDLE, START, RUN and DONE, with an 8-bit down-counter cnt.
REQ-025 IDLE SHALL go to START when d_mc & !lu & !br_taken; otherwise it stays in IDLE.
REQ-026 START SHALL last one cycle: mc_start=1, cnt loads MC_LAT-1, next state RUN.
REQ-027 RUN SHALL decrement cnt each cycle, and SHALL go to DONE in the cycle cnt=0.
REQ-028 DONE SHALL last one cycle: the multi-cycle instruction advances, next state IDLE.
REQ-029 Output priority, highest first, SHALL be: 1) br_taken; 2) FSM in START or RUN; 3) lu in IDLE; 4) otherwise.
REQ-030 On br_taken: flush_fd=1, bubble_de=1, wpcir=1.
REQ-031 If br_taken occurs in START or RUN, mc_abort=1 for that cycle and the next state SHALL be IDLE.
REQ-032 In START or RUN (without br_taken): wpcir=0, bubble_de=1, flush_fd=0.
REQ-033 On lu in IDLE: wpcir=0, bubble_de=1, flush_fd=0, and the FSM does not start.
REQ-034 Otherwise, and in DONE: wpcir=1, bubble_de=0, flush_fd=0.
REQ-035 mc_start SHALL never be asserted in the same cycle as mc_abort.
REQ-036 stall_cnt SHALL add 1 on each clock edge where wpcir=0 and rst=0.
REQ-037 stall_cnt SHALL hold at 16'hFFFF once reached.
REQ-038 A multi-cycle operation SHALL stall fetch for exactly MC_LAT+1 cycles (START plus MC_LAT RUN cycles).
REQ-039 The multi-cycle instruction SHALL leave D on the DONE edge.

Reset
REQ-040 While rst=1, the next state SHALL be IDLE, cnt 0 and stall_cnt 0.
REQ-041 While rst=1, combinational outputs SHALL be forced to wpcir=1, bubble_de=1, flush_fd=0, mc_start=0, mc_abort=0, mc_busy=0, fwda=fwdb=00.
REQ-042 Reset asserted mid-RUN SHALL abandon the operation with no mc_abort pulse; the next cycle after release SHALL be IDLE.

Verification
REQ-043 Forwarding scenario: e_wreg=1, e_rd=5, e_m2reg=0, m_wreg=1, m_rd=5, m_m2reg=1, d_rs1=d_rs2=5 -> fwda=fwdb=01; with d_rs1=0 -> fwda=00.
REQ-044 Load-use scenario: e_m2reg=1, e_wreg=1, e_rd=7, d_rs2=7, d_use_rs2=1 -> one cycle with wpcir=0, bubble_de=1; stall_cnt goes 0 -> 1.
REQ-045 Multi-cycle scenario: MC_LAT=4, d_mc=1 from IDLE -> mc_start pulse in cycle 1, mc_busy high for 5 cycles, wpcir=0 for 5 cycles, DONE in cycle 6, stall_cnt=5.
REQ-046 Abort scenario: br_taken=1 in the 2nd RUN cycle -> mc_abort=1, flush_fd=1, bubble_de=1, wpcir=1 that cycle, then IDLE.
REQ-047 Simultaneous scenario: lu=1 and br_taken=1 in IDLE -> branch wins: wpcir=1, flush_fd=1, no stall count.
REQ-048 Reset and saturation scenario: rst pulse in the 3rd RUN cycle -> IDLE after release, stall_cnt=0; 70000 forced stall cycles -> stall_cnt=16'hFFFF.

Source files
------------

// File: rtl/pl_hazard_ctrl.sv
// pl_hazard_ctrl: forwarding selects, load-use/branch/multi-cycle hazard control with stall counter
// Ports: clk/rst (sync, active-high); d_* decode sources, use flags, multi-cycle flag;
// e_*/m_* execute/memory write-back info; br_taken; fwda/fwdb operand selects;
// wpcir, bubble_de, flush_fd pipeline control; mc_start/mc_abort/mc_busy multi-cycle handshake;
// stall_cnt saturating count of stalled cycles.
module pl_hazard_ctrl #(
    parameter int unsigned MC_LAT = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  d_rs1,
    input  logic [4:0]  d_rs2,
    input  logic        d_use_rs1,
    input  logic        d_use_rs2,
    input  logic        d_mc,
    input  logic        e_wreg,
    input  logic        e_m2reg,
    input  logic [4:0]  e_rd,
    input  logic        m_wreg,
    input  logic        m_m2reg,
    input  logic [4:0]  m_rd,
    input  logic        br_taken,
    output logic [1:0]  fwda,
    output logic [1:0]  fwdb,
    output logic        wpcir,
    output logic        bubble_de,
    output logic        flush_fd,
    output logic        mc_start,
    output logic        mc_abort,
    output logic        mc_busy,
    output logic [15:0] stall_cnt
);
    typedef enum logic [1:0] {IDLE, START, RUN, DONE} state_t;
    state_t      r_state, w_next;
    logic [7:0]  r_cnt, w_cnt_next;
    logic [15:0] r_stall;
    logic        w_lu, w_busy;

    // A load in E cannot forward yet (data not available), so it selects the register file.
    function automatic logic [1:0] fwd_sel(input logic [4:0] r, input logic ew, input logic em,
                                           input logic [4:0] erd, input logic mw, input logic mm,
                                           input logic [4:0] mrd);
        return (r == 5'd0) ? 2'b00 :
               (ew && erd == r) ? (em ? 2'b00 : 2'b01) :
               (mw && mrd == r) ? (mm ? 2'b11 : 2'b10) : 2'b00;
    endfunction

    assign fwda = rst ? 2'b00 : fwd_sel(d_rs1, e_wreg, e_m2reg, e_rd, m_wreg, m_m2reg, m_rd);
    assign fwdb = rst ? 2'b00 : fwd_sel(d_rs2, e_wreg, e_m2reg, e_rd, m_wreg, m_m2reg, m_rd);
    assign w_lu = e_wreg && e_m2reg && e_rd != 5'd0 &&
                  ((d_use_rs1 && d_rs1 == e_rd) || (d_use_rs2 && d_rs2 == e_rd));
    assign w_busy    = r_state == START || r_state == RUN;
    assign mc_busy   = !rst && w_busy;
    assign stall_cnt = r_stall;

    always_comb begin
        w_next     = r_state;
        w_cnt_next = r_cnt;
        wpcir      = 1'b1;
        bubble_de  = 1'b0;
        flush_fd   = 1'b0;
        mc_start   = 1'b0;
        mc_abort   = 1'b0;
        if (rst) begin
            w_next     = IDLE;
            w_cnt_next = 8'd0;
            bubble_de  = 1'b1;
        end else if (br_taken) begin
            // Branch wins everything; any multi-cycle op in flight belongs to a squashed path.
            w_next    = IDLE;
            flush_fd  = 1'b1;
            bubble_de = 1'b1;
            mc_abort  = w_busy;
        end else begin
            case (r_state)
                IDLE: begin
                    wpcir     = !w_lu;
                    bubble_de = w_lu;
                    w_next    = (d_mc && !w_lu) ? START : IDLE;
                end
                START: begin
                    wpcir      = 1'b0;
                    bubble_de  = 1'b1;
                    mc_start   = 1'b1;
                    w_cnt_next = 8'(MC_LAT - 1);
                    w_next     = RUN;
                end
                RUN: begin
                    wpcir      = 1'b0;
                    bubble_de  = 1'b1;
                    w_cnt_next = r_cnt - 8'd1;
                    w_next     = (r_cnt == 8'd0) ? DONE : RUN;
                end
                DONE: w_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= 8'd0;
            r_stall <= 16'd0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_next;
            if (!wpcir && r_stall != 16'hFFFF) r_stall <= r_stall + 16'd1;
        end
    end
endmodule
